// File: rtl/key_encoder10_pkg.sv
// Shared types, constants and helpers for the 10-key debounced encoder.
package key_encoder10_pkg;

  localparam int unsigned CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_CHECK   = 2'd1;
  localparam state_t ST_HOLD    = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  // Index of the single set bit, or 4'hF when zero or several bits are set.
  function automatic logic [3:0] onehot10_to_bin(input logic [9:0] v);
    logic [3:0]  idx;
    int unsigned ones;
    idx  = 4'hF;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      if (v[i]) begin
        ones = ones + 1;
        idx  = 4'(i);
      end else begin
        idx  = idx;
      end
    end
    if (ones != 1) begin
      idx = 4'hF;
    end else begin
      idx = idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_encoder10_if.sv
// Key-line / code bus; D is 10 bits wide so a 10-line decoder output plugs straight in.
interface key_encoder10_if;
  logic       WD;
  logic [9:0] D;
  logic [3:0] Y;
  logic       valid;
  logic       err;
  logic       busy;

  modport master (output WD, D, input Y, valid, err, busy);
  modport slave  (input WD, D, output Y, valid, err, busy);
endinterface

// File: rtl/sync2.sv
// Parameterized-width two-flop synchronizer with synchronous active-high reset.
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= {WIDTH{1'b0}};
      sync_q <= {WIDTH{1'b0}};
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/key_encoder10.sv
// Debounced 10-key to BCD encoder: press and release must each be stable for DEB_CYCLES samples.
module key_encoder10
  import key_encoder10_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  key_encoder10_if.slave         bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [9:0]       s;
  logic [3:0]       code;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [9:0]       cand_q,  cand_d;
  logic [3:0]       y_q,     y_d;
  logic             valid_q, valid_d;
  logic             err_q,   err_d;
  logic             busy_q,  busy_d;

  sync2 #(.WIDTH(10)) u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (bus.D),
    .q   (s)
  );

  // Enable drop overrides every state; candidate is judged only when the check window completes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    y_d     = y_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    code    = onehot10_to_bin(cand_q);
    if (!bus.WD) begin
      state_d = ST_IDLE;
      cnt_d   = {CNT_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (s != 10'd0) begin
            cand_d  = s;
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_CHECK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CHECK: begin
          if (s != cand_q) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_HOLD;
            if (code != 4'hF) begin
              y_d     = code;
              valid_d = 1'b1;
            end else begin
              err_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (s == 10'd0) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_RELEASE: begin
          if (s != 10'd0) begin
            state_d = ST_HOLD;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      cand_q  <= 10'd0;
      y_q     <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.Y     = y_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule
